// File: rtl/rect_draw_scheduler_pkg.sv
// Shared definitions for the rectangle draw scheduler: FSM state encoding
// and default field widths.
package rect_draw_scheduler_pkg;

  localparam int COORD_W_DEF  = 8;
  localparam int COLOUR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAW  = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from
// ptr, wrapping modulo N. Returns a one-hot grant and its index.
module rr_arbiter
  import rect_draw_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  int               j;
  logic [IDX_W-1:0] k;

  // Scanning from the farthest candidate back to ptr lets the closest hit win.
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = 0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      k = IDX_W'(j);
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Shares one rectangle rasterizer between NUM_REQ clients with round-robin
// arbitration. Optional draw watchdog enabled by defining DRAW_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for any request; grant and latch fields on the same edge
// START | one-cycle rasterizer start pulse
// DRAW  | plot enabled until rast_done (or watchdog expiry)
// ACK   | one-cycle ack to the served client, pointer advances
module rect_draw_scheduler
  import rect_draw_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF
`ifdef DRAW_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*COORD_W-1:0]    req_x,
  input  logic [NUM_REQ*COORD_W-1:0]    req_y,
  input  logic [NUM_REQ*COORD_W-1:0]    req_w,
  input  logic [NUM_REQ*COORD_W-1:0]    req_h,
  input  logic [NUM_REQ*COLOUR_W-1:0]   req_colour,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [COORD_W-1:0]            rast_x,
  output logic [COORD_W-1:0]            rast_y,
  output logic [COORD_W-1:0]            rast_w,
  output logic [COORD_W-1:0]            rast_h,
  output logic                          rast_start,
  input  logic                          rast_done,
  output logic                          plot_en,
  output logic [COLOUR_W-1:0]           plot_colour
`ifdef DRAW_TIMEOUT_EN
  , output logic                        timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [COORD_W-1:0] sel_w, sel_h;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_valid = |arb_grant;
  assign sel_w     = req_w[arb_idx*COORD_W +: COORD_W];
  assign sel_h     = req_h[arb_idx*COORD_W +: COORD_W];

`ifdef DRAW_TIMEOUT_EN
  localparam int CNT_W = 2 * COORD_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] draw_cnt;
  logic             draw_expire;

  assign draw_expire = (state == DRAW) && !rast_done && (draw_cnt == TO_LAST);

  // Counter is cleared in START, which is the only way into DRAW.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START) draw_cnt <= '0;
      else if (state == DRAW) draw_cnt <= draw_cnt + 1'b1;
      if (draw_expire) timeout_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          // Empty rectangles skip the rasterizer entirely.
          if (sel_w == '0 || sel_h == '0) state_nxt = ACK;
          else state_nxt = START;
        end
      end
      START: state_nxt = DRAW;
      DRAW: begin
        if (rast_done) state_nxt = ACK;
`ifdef DRAW_TIMEOUT_EN
        else if (draw_expire) state_nxt = ACK;
`endif
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      rast_x      <= '0;
      rast_y      <= '0;
      rast_w      <= '0;
      rast_h      <= '0;
      plot_colour <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_valid) begin
        grant_id    <= arb_idx;
        rast_x      <= req_x[arb_idx*COORD_W +: COORD_W];
        rast_y      <= req_y[arb_idx*COORD_W +: COORD_W];
        rast_w      <= sel_w;
        rast_h      <= sel_h;
        plot_colour <= req_colour[arb_idx*COLOUR_W +: COLOUR_W];
      end
      if (state == ACK) begin
        if (int'(grant_id) == NUM_REQ - 1) rr_ptr <= '0;
        else rr_ptr <= grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == ACK) ack[grant_id] = 1'b1;
  end

  assign busy       = (state != IDLE);
  assign rast_start = (state == START);
  assign plot_en    = (state == DRAW) && !rast_done;

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Directed bench for rect_draw_scheduler; timeout section active when
// DRAW_TIMEOUT_EN is defined.
module tb_rect_draw_scheduler;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int KW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] req_x, req_y, req_w, req_h;
  logic [NR*KW-1:0] req_colour;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [1:0]       grant_id;
  logic [CW-1:0]    rast_x, rast_y, rast_w, rast_h;
  logic             rast_start;
  logic             rast_done;
  logic             plot_en;
  logic [KW-1:0]    plot_colour;
`ifdef DRAW_TIMEOUT_EN
  logic             timeout_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_start = 0;

  rect_draw_scheduler #(
    .NUM_REQ(NR), .COORD_W(CW), .COLOUR_W(KW)
`ifdef DRAW_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour), .ack(ack), .busy(busy), .grant_id(grant_id),
    .rast_x(rast_x), .rast_y(rast_y), .rast_w(rast_w), .rast_h(rast_h),
    .rast_start(rast_start), .rast_done(rast_done),
    .plot_en(plot_en), .plot_colour(plot_colour)
`ifdef DRAW_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rast_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; rast_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Latency counts the cycle in which req was raised as cycle 1.
  task automatic wait_ack(input string tag, input logic drop, input int max,
                          output int id, output int lat, output int pe);
    id = -1; lat = 0; pe = 0;
    for (int n = 1; n <= max && id < 0; n++) begin
      @(negedge clk);
      if (plot_en) pe++;
      if (ack != '0) begin
        for (int k = 0; k < NR; k++) if (ack[k]) id = k;
        lat = n + 1;
        if (drop) req[id] = 1'b0;
      end
    end
    chk({tag, "_seen"}, 32'(id >= 0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int id, lat, pe, s0, seen;
    reset = 1'b1; req = '0; rast_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_x[i*CW +: CW] = CW'(i*10 + 1);
      req_y[i*CW +: CW] = CW'(i*10 + 2);
      req_w[i*CW +: CW] = 8'd2;
      req_h[i*CW +: CW] = 8'd2;
      req_colour[i*KW +: KW] = KW'(i + 1);
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_start", rast_start, 0);
    chk("rst_plot", plot_en, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_x", rast_x, 0);
    chk("rst_colour", plot_colour, 0);
    reset = 1'b0;

    // Single client 2: start, 15 plot cycles, done, ack.
    req_x[2*CW +: CW] = 8'd10; req_y[2*CW +: CW] = 8'd20;
    req_w[2*CW +: CW] = 8'd5;  req_h[2*CW +: CW] = 8'd3;
    req_colour[2*KW +: KW] = 3'b100;
    s0 = n_start;
    req = 4'b0100;
    @(negedge clk);
    chk("s_start", rast_start, 1);
    chk("s_gid", grant_id, 2);
    chk("s_x", rast_x, 10);
    chk("s_y", rast_y, 20);
    chk("s_w", rast_w, 5);
    chk("s_h", rast_h, 3);
    chk("s_colour", plot_colour, 4);
    chk("s_busy", busy, 1);
    req_x[2*CW +: CW] = 8'd99;
    pe = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (plot_en) pe++;
    end
    chk("s_plot_cnt", pe, 15);
    chk("s_x_hold", rast_x, 10);
    @(negedge clk);
    rast_done = 1'b1;
    #1;
    chk("s_plot_drop", plot_en, 0);
    chk("s_no_ack_yet", ack, 0);
    @(negedge clk);
    chk("s_ack", ack, 4'b0100);
    req = '0; rast_done = 1'b0;
    @(negedge clk);
    chk("s_idle", busy, 0);
    chk("s_ack_pulse", ack, 0);
    chk("s_one_start", n_start - s0, 1);
    req_x[2*CW +: CW] = 8'd21;

    // Minimum latency with rast_done already high.
    rast_done = 1'b1;
    req = 4'b0001;
    wait_ack("minlat", 1'b1, 20, id, lat, pe);
    chk("minlat_id", id, 0);
    chk("minlat_lat", lat, 4);

    // Contention: all four, two rounds from pointer 0.
    do_reset();
    rast_done = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111;
      for (int k = 0; k < NR; k++) begin
        wait_ack("cont", 1'b1, 20, id, lat, pe);
        chk($sformatf("cont_r%0d_k%0d", r, k), id, k);
      end
      @(negedge clk);
    end

    // Fairness: client 0 held, client 1 raised mid-draw of client 0.
    do_reset();
    rast_done = 1'b0;
    req = 4'b0001;
    seen = 0;
    for (int n = 0; n < 10 && seen == 0; n++) begin
      @(negedge clk);
      if (plot_en) seen = 1;
    end
    chk("fair_draw", seen, 1);
    req[1] = 1'b1;
    rast_done = 1'b1;
    wait_ack("fair", 1'b0, 20, id, lat, pe);
    chk("fair_first", id, 0);
    wait_ack("fair", 1'b1, 20, id, lat, pe);
    chk("fair_second", id, 1);
    wait_ack("fair", 1'b0, 20, id, lat, pe);
    chk("fair_third", id, 0);
    req = '0;

    // Zero-size rectangle on client 1.
    @(negedge clk);
    req_w[1*CW +: CW] = 8'd0; req_h[1*CW +: CW] = 8'd7;
    rast_done = 1'b0;
    s0 = n_start;
    req = 4'b0010;
    wait_ack("zero", 1'b1, 20, id, lat, pe);
    chk("zero_id", id, 1);
    chk("zero_lat", lat, 2);
    chk("zero_plot", pe, 0);
    chk("zero_start", n_start - s0, 0);
    req_w[1*CW +: CW] = 8'd2; req_h[1*CW +: CW] = 8'd2;
    @(negedge clk);

    // Reset during DRAW of client 3 (pointer sits at 2 beforehand).
    req = 4'b1000;
    seen = 0;
    for (int n = 0; n < 10 && seen == 0; n++) begin
      @(negedge clk);
      if (plot_en) seen = 1;
    end
    chk("rd_draw", seen, 1);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("rd_plot", plot_en, 0);
    chk("rd_busy", busy, 0);
    chk("rd_ack", ack, 0);
    chk("rd_gid", grant_id, 0);
    reset = 1'b0;
    rast_done = 1'b1;
    req = 4'b1010;
    wait_ack("rd_ptr", 1'b1, 20, id, lat, pe);
    chk("rd_ptr_id", id, 1);
    req = '0;
    @(negedge clk);

`ifdef DRAW_TIMEOUT_EN
    do_reset();
    chk("to_init", timeout_err, 0);
    rast_done = 1'b0;
    req = 4'b0001;
    wait_ack("to", 1'b1, 300, id, lat, pe);
    chk("to_id", id, 0);
    chk("to_plot_cycles", pe, 100);
    @(negedge clk);
    chk("to_err", timeout_err, 1);
    rast_done = 1'b1;
    req = 4'b0010;
    wait_ack("to_next", 1'b1, 20, id, lat, pe);
    @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    do_reset();
    chk("to_clear", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
